// File: rtl/instr_register_sched_pkg.sv
// Shared types for the instruction register and its write/issue scheduler.
// Opcode/operand/instruction types plus requester-id and queue-depth constants.
package instr_register_sched_pkg;

  typedef enum logic [3:0] {
    ZERO,
    PASSA,
    PASSB,
    ADD,
    SUB,
    MULT,
    DIV,
    MOD
  } opcode_t;

  typedef logic signed [31:0] operand_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
  } instruction_t;

  localparam int REQ_ID_W    = 3;
  localparam int SCHED_DEPTH = 32;

  typedef logic [REQ_ID_W-1:0] req_id_t;

endpackage

// File: rtl/instr_register_sched_if.sv
// Requester and issue-side bus of the scheduler.
// master: requesters + consumer; slave: the scheduler.
interface instr_register_sched_if
  import instr_register_sched_pkg::*;
#(
  parameter int NUM_REQ = 2
) ();

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  opcode_t            req_opcode    [NUM_REQ];
  operand_t           req_operand_a [NUM_REQ];
  operand_t           req_operand_b [NUM_REQ];

  logic               issue_valid;
  logic               issue_ready;
  instruction_t       issue_word;
  req_id_t            issue_src;

  modport master (
    output req_valid,
    output req_opcode,
    output req_operand_a,
    output req_operand_b,
    input  req_ready,
    output issue_ready,
    input  issue_valid,
    input  issue_word,
    input  issue_src
  );

  modport slave (
    input  req_valid,
    input  req_opcode,
    input  req_operand_a,
    input  req_operand_b,
    output req_ready,
    input  issue_ready,
    output issue_valid,
    output issue_word,
    output issue_src
  );

endinterface

// File: rtl/instr_register_sched_rr_arbiter.sv
// One-hot round-robin arbiter with a rotating last-grant register.
// Ports: clk, reset_n (sync, active-low), i_req, i_advance (commit grant), o_gnt.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_gnt
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] r_last;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_j;
  logic          w_hit;

  // scan starts just after the last winner and wraps
  always_comb begin
    o_gnt = '0;
    w_idx = r_last;
    w_hit = 1'b0;
    w_j   = '0;
    for (int i = 1; i <= N; i++) begin
      w_j = IW'((int'(r_last) + i) % N);
      if (!w_hit && i_req[w_j]) begin
        w_hit      = 1'b1;
        w_idx      = w_j;
        o_gnt[w_j] = 1'b1;
      end
    end
  end

  // reset to N-1 so requester 0 has first priority
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last <= IW'(N - 1);
    end else if (i_advance) begin
      r_last <= w_idx;
    end
  end

endmodule

// File: rtl/instr_register_sched.sv
// Round-robin write-port scheduler and circular FIFO issuer for instr_register.
// Ports: clk, reset_n, i_flush, bus (slave), o_load_en/o_write_pointer/o_opcode/
// o_operand_a/o_operand_b/o_read_pointer to the register, i_instruction_word, o_count.
module instr_register_sched
  import instr_register_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DEPTH   = SCHED_DEPTH,
  parameter int PTR_W   = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_flush,
  instr_register_sched_if.slave bus,
  output logic                o_load_en,
  output logic [PTR_W-1:0]    o_write_pointer,
  output opcode_t             o_opcode,
  output operand_t            o_operand_a,
  output operand_t            o_operand_b,
  output logic [PTR_W-1:0]    o_read_pointer,
  input  instruction_t        i_instruction_word,
  output logic [PTR_W:0]      o_count
);

  localparam logic [PTR_W:0]   FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PONE = PTR_W'(1);

  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic [PTR_W:0]     r_alloc;
  logic               r_load_en;
  logic [PTR_W-1:0]   r_wp;
  opcode_t            r_opc;
  operand_t           r_a;
  operand_t           r_b;
  req_id_t            r_src_tag [DEPTH];

  logic               w_en;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_xfer;
  logic               w_issue;
  req_id_t            w_sel;
  opcode_t            w_opc;
  operand_t           w_a;
  operand_t           w_b;

  // alloc counts in-flight writes, so a full queue stops granting early
  assign w_en  = reset_n && !i_flush && (r_alloc != FULL);
  assign w_req = bus.req_valid & {NUM_REQ{w_en}};

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (w_req),
    .i_advance(w_xfer),
    .o_gnt    (w_gnt)
  );

  assign w_xfer        = |w_gnt;
  assign bus.req_ready = w_gnt;

  always_comb begin
    w_sel = '0;
    w_opc = ZERO;
    w_a   = '0;
    w_b   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel = REQ_ID_W'(i);
        w_opc = bus.req_opcode[i];
        w_a   = bus.req_operand_a[i];
        w_b   = bus.req_operand_b[i];
      end
    end
  end

  assign bus.issue_valid = (r_count != '0);
  assign bus.issue_word  = i_instruction_word;
  assign bus.issue_src   = r_src_tag[r_rd_ptr];
  assign w_issue         = bus.issue_valid && bus.issue_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_alloc   <= '0;
      r_load_en <= 1'b0;
      r_wp      <= '0;
      r_opc     <= ZERO;
      r_a       <= '0;
      r_b       <= '0;
    end else if (i_flush) begin
      // a write registered for this edge still lands, but is forgotten
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_alloc   <= '0;
      r_load_en <= 1'b0;
    end else begin
      r_load_en <= w_xfer;
      if (w_xfer) begin
        r_wp     <= r_wr_ptr;
        r_opc    <= w_opc;
        r_a      <= w_a;
        r_b      <= w_b;
        r_wr_ptr <= r_wr_ptr + PONE;
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PONE;
      end
      unique case ({w_xfer, w_issue})
        2'b10:   r_alloc <= r_alloc + CONE;
        2'b01:   r_alloc <= r_alloc - CONE;
        default: r_alloc <= r_alloc;
      endcase
      unique case ({r_load_en, w_issue})
        2'b10:   r_count <= r_count + CONE;
        2'b01:   r_count <= r_count - CONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // tag captured at grant time; it is ready long before the entry issues
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_src_tag[r_wr_ptr] <= w_sel;
    end
  end

  assign o_load_en       = r_load_en;
  assign o_write_pointer = r_wp;
  assign o_opcode        = r_opc;
  assign o_operand_a     = r_a;
  assign o_operand_b     = r_b;
  assign o_read_pointer  = r_rd_ptr;
  assign o_count         = r_count;

  a_cnt_bounds: assert property (
    @(posedge clk) disable iff (!reset_n)
    (r_count <= FULL) && (r_alloc <= FULL) && (r_count <= r_alloc)
  );

  a_rdy_valid: assert property (
    @(posedge clk) (bus.req_ready & ~bus.req_valid) == '0
  );

endmodule

// File: tb/tb_instr_register_sched.sv
// Directed bench for instr_register_sched with a behavioural instr_register.
// Vector table for round-robin flow, hand sequences for full, overlap and flush.
module tb_instr_register_sched;
  import instr_register_sched_pkg::*;

  typedef struct {
    logic [1:0] v;
    logic       ir;
    int         a0;
    int         a1;
    logic [1:0] rdy;
    logic       ld;
    int         wp;
    int         cnt;
    logic       iv;
    int         src;
    int         a;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         ld;
  logic [4:0]   wp;
  logic [4:0]   rp;
  opcode_t      opc;
  operand_t     oa;
  operand_t     ob;
  instruction_t iw;
  logic [5:0]   cnt;
  instruction_t mem [32];
  vec_t         tbl [13];
  int           n_chk = 0;
  int           n_fail = 0;
  int           ngr;

  instr_register_sched_if #(.NUM_REQ(2)) bus ();

  instr_register_sched #(
    .NUM_REQ(2),
    .DEPTH  (32),
    .PTR_W  (5)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_flush           (flush),
    .bus               (bus),
    .o_load_en         (ld),
    .o_write_pointer   (wp),
    .o_opcode          (opc),
    .o_operand_a       (oa),
    .o_operand_b       (ob),
    .o_read_pointer    (rp),
    .i_instruction_word(iw),
    .o_count           (cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld) mem[wp] <= instruction_t'{opc, oa, ob};
  end
  assign iw = mem[rp];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 2'b11;
    bus.issue_ready = 1'b0;
    next();
    next();
    settle();
    chk("rst.rdy", 64'(bus.req_ready), 64'd0);
    chk("rst.ld", 64'(ld), 64'd0);
    chk("rst.cnt", 64'(cnt), 64'd0);
    chk("rst.iv", 64'(bus.issue_valid), 64'd0);
    chk("rst.wp", 64'(wp), 64'd0);
    chk("rst.rp", 64'(rp), 64'd0);
    chk("rst.opc", 64'(opc), 64'(ZERO));
    chk("rst.oa", 64'(oa), 64'd0);
    bus.req_valid = 2'b00;
    reset_n = 1'b1;
    next();
  endtask

  initial begin
    reset_n = 1'b0;
    flush = 1'b0;
    bus.req_valid = 2'b00;
    bus.issue_ready = 1'b0;
    bus.req_opcode[0] = ADD;
    bus.req_opcode[1] = SUB;
    bus.req_operand_a[0] = 5;
    bus.req_operand_a[1] = 0;
    bus.req_operand_b[0] = 3;
    bus.req_operand_b[1] = 0;

    //         v     ir    a0   a1   rdy   ld  wp cnt iv  src a
    tbl[0]  = '{2'b11, 1'b0, 100, 101, 2'b01, 1'b0, 0, 0, 1'b0, 0, 0};
    tbl[1]  = '{2'b11, 1'b0, 110, 111, 2'b10, 1'b1, 0, 0, 1'b0, 0, 0};
    tbl[2]  = '{2'b11, 1'b0, 120, 121, 2'b01, 1'b1, 1, 1, 1'b1, 0, 100};
    tbl[3]  = '{2'b11, 1'b0, 130, 131, 2'b10, 1'b1, 2, 2, 1'b1, 0, 100};
    tbl[4]  = '{2'b11, 1'b0, 140, 141, 2'b01, 1'b1, 3, 3, 1'b1, 0, 100};
    tbl[5]  = '{2'b11, 1'b0, 150, 151, 2'b10, 1'b1, 4, 4, 1'b1, 0, 100};
    tbl[6]  = '{2'b00, 1'b1, 0,   0,   2'b00, 1'b1, 5, 5, 1'b1, 0, 100};
    tbl[7]  = '{2'b00, 1'b1, 0,   0,   2'b00, 1'b0, 0, 5, 1'b1, 1, 111};
    tbl[8]  = '{2'b00, 1'b1, 0,   0,   2'b00, 1'b0, 0, 4, 1'b1, 0, 120};
    tbl[9]  = '{2'b00, 1'b1, 0,   0,   2'b00, 1'b0, 0, 3, 1'b1, 1, 131};
    tbl[10] = '{2'b00, 1'b1, 0,   0,   2'b00, 1'b0, 0, 2, 1'b1, 0, 140};
    tbl[11] = '{2'b00, 1'b1, 0,   0,   2'b00, 1'b0, 0, 1, 1'b1, 1, 151};
    tbl[12] = '{2'b00, 1'b0, 0,   0,   2'b00, 1'b0, 0, 0, 1'b0, 0, 0};

    // reset with both requesters asserted
    do_reset();

    // single write then issue
    bus.req_valid = 2'b01;
    settle();
    chk("one.rdy", 64'(bus.req_ready), 64'd1);
    next();
    bus.req_valid = 2'b00;
    settle();
    chk("one.ld", 64'(ld), 64'd1);
    chk("one.wp", 64'(wp), 64'd0);
    chk("one.iv0", 64'(bus.issue_valid), 64'd0);
    next();
    bus.issue_ready = 1'b1;
    settle();
    chk("one.iv", 64'(bus.issue_valid), 64'd1);
    chk("one.opc", 64'(bus.issue_word.opc), 64'(ADD));
    chk("one.a", 64'(bus.issue_word.op_a), 64'd5);
    chk("one.b", 64'(bus.issue_word.op_b), 64'd3);
    chk("one.src", 64'(bus.issue_src), 64'd0);
    next();
    bus.issue_ready = 1'b0;
    settle();
    chk("one.empty", 64'(bus.issue_valid), 64'd0);
    chk("one.rp", 64'(rp), 64'd1);
    next();

    // reset restores priority to requester 0, then round-robin table
    do_reset();
    bus.req_operand_b[0] = 0;
    for (int k = 0; k < 13; k++) begin
      bus.req_valid = tbl[k].v;
      bus.issue_ready = tbl[k].ir;
      bus.req_operand_a[0] = tbl[k].a0;
      bus.req_operand_a[1] = tbl[k].a1;
      settle();
      chk($sformatf("rr%0d.rdy", k), 64'(bus.req_ready), 64'(tbl[k].rdy));
      chk($sformatf("rr%0d.ld", k), 64'(ld), 64'(tbl[k].ld));
      chk($sformatf("rr%0d.cnt", k), 64'(cnt), 64'(tbl[k].cnt));
      chk($sformatf("rr%0d.iv", k), 64'(bus.issue_valid), 64'(tbl[k].iv));
      if (tbl[k].ld)
        chk($sformatf("rr%0d.wp", k), 64'(wp), 64'(tbl[k].wp));
      if (tbl[k].iv) begin
        chk($sformatf("rr%0d.src", k), 64'(bus.issue_src), 64'(tbl[k].src));
        chk($sformatf("rr%0d.a", k), 64'(bus.issue_word.op_a), 64'(tbl[k].a));
      end
      next();
    end

    // fill to full with 33 requests, then one issue frees one slot
    do_reset();
    bus.req_valid = 2'b01;
    ngr = 0;
    for (int k = 0; k < 33; k++) begin
      bus.req_operand_a[0] = k;
      settle();
      if (bus.req_ready[0]) ngr++;
      next();
    end
    chk("full.grants", 64'(ngr), 64'd32);
    bus.issue_ready = 1'b1;
    settle();
    chk("full.rdy", 64'(bus.req_ready), 64'd0);
    chk("full.cnt", 64'(cnt), 64'd32);
    chk("full.a0", 64'(bus.issue_word.op_a), 64'd0);
    next();
    bus.issue_ready = 1'b0;
    settle();
    chk("full.regrant", 64'(bus.req_ready), 64'd1);
    chk("full.cnt31", 64'(cnt), 64'd31);
    next();
    bus.req_valid = 2'b00;
    settle();
    chk("wrap.ld", 64'(ld), 64'd1);
    chk("wrap.wp", 64'(wp), 64'd0);
    chk("wrap.oa", 64'(oa), 64'd32);
    next();
    settle();
    chk("wrap.cnt", 64'(cnt), 64'd32);
    chk("wrap.a1", 64'(bus.issue_word.op_a), 64'd1);
    next();

    // steady grant + issue at constant occupancy
    do_reset();
    bus.req_valid = 2'b01;
    for (int k = 0; k < 15; k++) begin
      bus.req_operand_a[0] = k;
      bus.issue_ready = (k >= 5);
      settle();
      if (k >= 5) begin
        chk($sformatf("sim%0d.cnt", k), 64'(cnt), 64'd4);
        chk($sformatf("sim%0d.rdy", k), 64'(bus.req_ready), 64'd1);
        chk($sformatf("sim%0d.rp", k), 64'(rp), 64'(k - 5));
        chk($sformatf("sim%0d.wp", k), 64'(wp), 64'(k - 1));
        chk($sformatf("sim%0d.a", k), 64'(bus.issue_word.op_a), 64'(k - 5));
      end
      next();
    end
    bus.req_valid = 2'b00;
    bus.issue_ready = 1'b0;

    // flush while a write is in flight
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_operand_a[0] = 77;
    next();
    bus.req_operand_a[0] = 78;
    next();
    flush = 1'b1;
    settle();
    chk("fl.rdy", 64'(bus.req_ready), 64'd0);
    chk("fl.ld", 64'(ld), 64'd1);
    chk("fl.wp", 64'(wp), 64'd1);
    chk("fl.cnt", 64'(cnt), 64'd1);
    next();
    flush = 1'b0;
    bus.req_operand_a[0] = 99;
    settle();
    chk("fl.cnt0", 64'(cnt), 64'd0);
    chk("fl.iv0", 64'(bus.issue_valid), 64'd0);
    chk("fl.ld0", 64'(ld), 64'd0);
    chk("fl.rp0", 64'(rp), 64'd0);
    chk("fl.rdy1", 64'(bus.req_ready), 64'd1);
    next();
    bus.req_valid = 2'b00;
    settle();
    chk("fl.ld1", 64'(ld), 64'd1);
    chk("fl.wp0", 64'(wp), 64'd0);
    next();
    bus.issue_ready = 1'b1;
    settle();
    chk("fl.iv1", 64'(bus.issue_valid), 64'd1);
    chk("fl.a99", 64'(bus.issue_word.op_a), 64'd99);
    chk("fl.cnt1", 64'(cnt), 64'd1);
    next();
    bus.issue_ready = 1'b0;
    settle();
    chk("fl.gone", 64'(bus.issue_valid), 64'd0);
    chk("fl.cntz", 64'(cnt), 64'd0);
    chk("fl.rp1", 64'(rp), 64'd1);
    next();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
